tank_key_decoder: RTL and testbench



---
 rtl/tank_pkg.sv | 22 ++
 rtl/tank_player_decode.sv | 72 +++++++
 rtl/tank_key_decoder.sv | 34 +++
 tb/tb_tank_key_decoder.sv | 101 ++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// tank_pkg: shared types, HID key codes and key-match helpers for the tank key decoder.
package tank_pkg;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_RIGHT = 2'd1, DIR_DOWN = 2'd2, DIR_LEFT = 2'd3} dir_t;
   typedef enum logic {READY = 1'b0, COOL = 1'b1} fire_state_t;
   localparam logic [7:0] P1_UP = 8'h1A;
   localparam logic [7:0] P1_LEFT = 8'h04;
   localparam logic [7:0] P1_DOWN = 8'h16;
   localparam logic [7:0] P1_RIGHT = 8'h07;
   localparam logic [7:0] P1_FIRE = 8'h2C;
   localparam logic [7:0] P2_UP = 8'h52;
   localparam logic [7:0] P2_DOWN = 8'h51;
   localparam logic [7:0] P2_LEFT = 8'h50;
   localparam logic [7:0] P2_RIGHT = 8'h4F;
   localparam logic [7:0] P2_FIRE = 8'h28;
   function automatic logic has_key(input logic [31:0] kc, input logic [7:0] code);
      return (kc[31:24] == code) || (kc[23:16] == code) || (kc[15:8] == code) || (kc[7:0] == code);
   endfunction
   // held vectors are indexed by dir_t encoding; priority is up > down > left > right
   function automatic dir_t pick_dir(input logic [3:0] v);
      return v[0] ? DIR_UP : v[2] ? DIR_DOWN : v[3] ? DIR_LEFT : DIR_RIGHT;
   endfunction
endpackage

// File: rtl/tank_player_decode.sv
// tank_player_decode: one player's last-pressed-wins direction and rate-limited fire pulse.
// TANK_AUTOFIRE_EN: a held fire key re-fires whenever the cooldown has expired.
module tank_player_decode
   import tank_pkg::*;
#(
   parameter logic [7:0]  UP_KEY        = P1_UP,
   parameter logic [7:0]  RIGHT_KEY     = P1_RIGHT,
   parameter logic [7:0]  DOWN_KEY      = P1_DOWN,
   parameter logic [7:0]  LEFT_KEY      = P1_LEFT,
   parameter logic [7:0]  FIRE_KEY      = P1_FIRE,
   parameter int unsigned FIRE_COOLDOWN = 30,
   parameter int unsigned CD_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] keycode_i,
   output logic [1:0]  dir_o,
   output logic        move_o,
   output logic        fire_o
);
   logic [3:0] held, new_keys, prev_held_q;
   logic held_fire, trig, prev_fire_q, prev_fire_d, fire_q, fire_d, move_q;
   dir_t dir_q, dir_d;
   fire_state_t state_q, state_d;
   logic [CD_W-1:0] cd_q, cd_d;

   assign held = {has_key(keycode_i, LEFT_KEY), has_key(keycode_i, DOWN_KEY),
                  has_key(keycode_i, RIGHT_KEY), has_key(keycode_i, UP_KEY)};
   assign held_fire = has_key(keycode_i, FIRE_KEY);
   assign new_keys = held & ~prev_held_q;
   assign trig = held_fire & ~prev_fire_q;
`ifdef TANK_AUTOFIRE_EN
   // prev_fire becomes a lockout cleared only by the first release after reset
   assign prev_fire_d = held_fire & prev_fire_q;
`else
   assign prev_fire_d = held_fire;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= READY;
         cd_q        <= '0;
         fire_q      <= 1'b0;
         prev_fire_q <= 1'b1;
         prev_held_q <= '0;
         dir_q       <= DIR_UP;
         move_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cd_q        <= cd_d;
         fire_q      <= fire_d;
         prev_fire_q <= prev_fire_d;
         prev_held_q <= held;
         dir_q       <= dir_d;
         move_q      <= |held;
      end
   end

   always_comb begin
      state_d = (state_q == READY) ? (trig ? COOL : READY) : ((cd_q == CD_W'(1)) ? READY : COOL);
      cd_d    = (state_q == READY) ? (trig ? CD_W'(FIRE_COOLDOWN) : cd_q) : cd_q - 1'b1;
   end

   always_comb begin
      fire_d = (state_q == READY) & trig;
      dir_d  = (|new_keys) ? pick_dir(new_keys) : (!held[dir_q] && (|held)) ? pick_dir(held) : dir_q;
   end

   assign dir_o  = dir_q;
   assign move_o = move_q;
   assign fire_o = fire_q;
endmodule

// File: rtl/tank_key_decoder.sv
// tank_key_decoder: splits the 4-slot USB keycode word into independent player 1 / player 2 commands.
// TANK_AUTOFIRE_EN (optional): held fire auto-repeats every FIRE_COOLDOWN+1 frames.
module tank_key_decoder
   import tank_pkg::*;
#(
   parameter int unsigned FIRE_COOLDOWN = 30,
   parameter int unsigned CD_W          = 8
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [31:0] keycode,
   output logic [1:0]  p1_dir,
   output logic        p1_move,
   output logic        p1_fire,
   output logic [1:0]  p2_dir,
   output logic        p2_move,
   output logic        p2_fire
);
   tank_player_decode #(
      .UP_KEY(P1_UP), .RIGHT_KEY(P1_RIGHT), .DOWN_KEY(P1_DOWN), .LEFT_KEY(P1_LEFT),
      .FIRE_KEY(P1_FIRE), .FIRE_COOLDOWN(FIRE_COOLDOWN), .CD_W(CD_W)
   ) u_p1 (
      .clk_i(frame_clk), .rst_i(Reset), .keycode_i(keycode),
      .dir_o(p1_dir), .move_o(p1_move), .fire_o(p1_fire)
   );

   tank_player_decode #(
      .UP_KEY(P2_UP), .RIGHT_KEY(P2_RIGHT), .DOWN_KEY(P2_DOWN), .LEFT_KEY(P2_LEFT),
      .FIRE_KEY(P2_FIRE), .FIRE_COOLDOWN(FIRE_COOLDOWN), .CD_W(CD_W)
   ) u_p2 (
      .clk_i(frame_clk), .rst_i(Reset), .keycode_i(keycode),
      .dir_o(p2_dir), .move_o(p2_move), .fire_o(p2_fire)
   );
endmodule

// File: tb/tb_tank_key_decoder.sv
// tb_tank_key_decoder: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_tank_key_decoder;
`ifdef TANK_AUTOFIRE_EN
   localparam bit AF = 1'b1;
`else
   localparam bit AF = 1'b0;
`endif
   typedef struct {
      logic [7:0] exp;
      string      name;
   } item_t;

   logic        frame_clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] keycode = '0;
   logic [1:0]  p1_dir, p2_dir;
   logic        p1_move, p1_fire, p2_move, p2_fire;
   item_t       sb[$];
   int          checks = 0;
   int          errors = 0;

   tank_key_decoder #(.FIRE_COOLDOWN(3), .CD_W(8)) dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .p1_dir(p1_dir), .p1_move(p1_move), .p1_fire(p1_fire),
      .p2_dir(p2_dir), .p2_move(p2_move), .p2_fire(p2_fire)
   );

   always #5 frame_clk = ~frame_clk;

   // outputs lag keycode by one edge: the entry pushed before an edge is checked just after it
   always @(posedge frame_clk) begin
      #1;
      if (sb.size() > 0) begin
         item_t it;
         logic [7:0] act;
         it = sb.pop_front();
         act = {p1_dir, p1_move, p1_fire, p2_dir, p2_move, p2_fire};
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got p1{dir,mv,fire}/p2{dir,mv,fire}=%b_%b_%b/%b_%b_%b expected %b_%b_%b/%b_%b_%b",
                     it.name, act[7:6], act[5], act[4], act[3:2], act[1], act[0],
                     it.exp[7:6], it.exp[5], it.exp[4], it.exp[3:2], it.exp[1], it.exp[0]);
         end
      end
   end

   task automatic step(input logic r, input logic [31:0] kc, input logic [1:0] d1, input logic m1,
                       input logic f1, input logic [1:0] d2, input logic m2, input logic f2, input string nm);
      item_t it;
      @(negedge frame_clk);
      Reset = r;
      keycode = kc;
      it.exp = {d1, m1, f1, d2, m2, f2};
      it.name = nm;
      sb.push_back(it);
   endtask

   initial begin
      step(1, 32'h0, 0, 0, 0, 0, 0, 0, "reset_idle");
      step(1, 32'h2C, 0, 0, 0, 0, 0, 0, "reset_space_held");
      step(0, 32'h2C, 0, 0, 0, 0, 0, 0, "space_held_through_reset");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "space_release");
      step(0, 32'h2C, 0, 0, 1, 0, 0, 0, "space_repress_fires");
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0, 0, 0, 0, "p1_cooling");
      step(0, 32'h07, 1, 1, 0, 0, 0, 0, "d_right");
      step(0, 32'h0407, 3, 1, 0, 0, 0, 0, "d_plus_a_left");
      step(0, 32'h07, 1, 1, 0, 0, 0, 0, "a_release_fallback_right");
      step(0, 32'h0, 1, 0, 0, 0, 0, 0, "release_dir_holds");
      step(0, 32'h1A160000, 0, 1, 0, 0, 0, 0, "w_s_same_cycle_up");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "release_up_holds");
      step(0, 32'h28, 0, 0, 0, 0, 0, 1, "enter_c0_fires");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "enter_c1_cool");
      step(0, 32'h28, 0, 0, 0, 0, 0, 0, "enter_c2_dropped");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "enter_c3_cool");
      step(0, 32'h28, 0, 0, 0, 0, 0, 1, "enter_c4_ready_fires");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "p2_cool_a");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "p2_cool_b");
      step(0, 32'h28, 0, 0, 0, 0, 0, 0, "enter_on_cd_zero_dropped");
      step(0, 32'h28, 0, 0, 0, 0, 0, AF, "enter_held_after_cd");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "enter_release");
      step(0, 32'h522C4F07, 1, 1, 1, 0, 1, 0, "mixed_players");
      for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0, 0, 0, 0, 0, "mixed_release");
      for (int i = 0; i < 12; i++)
         step(0, 32'h2C, 1, 0, logic'((i == 0) || (AF && (i % 4 == 0))), 0, 0, 0, "space_held_12");
      step(0, 32'h0, 1, 0, 0, 0, 0, 0, "space_held_release");
      step(0, 32'h2C, 1, 0, 1, 0, 0, 0, "space_fire_before_reset");
      step(1, 32'h0, 0, 0, 0, 0, 0, 0, "reset_mid_cooldown");
      step(0, 32'h2C, 0, 0, 0, 0, 0, 0, "post_reset_needs_edge");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "post_reset_release");
      step(0, 32'h2C, 0, 0, 1, 0, 0, 0, "post_reset_fire");
      step(0, 32'h0, 0, 0, 0, 0, 0, 0, "final_idle");
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge frame_clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
